// File: rtl/cpu_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cpu_test_sequencer                                             |
// | Brief   : Preloads dmem/imem, runs the cpu until STOP, then checks a     |
// |           dmem window against an expected-value source.                  |
// | Option  : CPU_SEQ_WATCHDOG_EN enables the RUN-state watchdog.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_test_sequencer #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int IMEM_DEPTH  = 512,
    parameter int DMEM_DEPTH  = 1024,
    parameter int CHK_BASE    = 35,
    parameter int CHK_LEN     = 12,
    parameter int CYC_W       = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [31:0]       instr,
    output logic              cpu_enable,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic [15:0]       exp_idx,
    input  logic [DATA_W-1:0] exp_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [3:0]        test_id,
    output logic [CYC_W-1:0]  cycles,
    output logic [15:0]       err_cnt,
    output logic [15:0]       first_err_idx
);

    localparam int         MAX_DEPTH = (DMEM_DEPTH > IMEM_DEPTH) ? DMEM_DEPTH : IMEM_DEPTH;
    localparam int         IDX_W     = $clog2(MAX_DEPTH) + 1;
    localparam logic [6:0] STOP_OPC  = 7'b1111110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_D = 3'd1,
        S_LOAD_I = 3'd2,
        S_RUN    = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       chk_q, chk_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic [3:0]        test_id_q, test_id_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       first_err_q, first_err_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
`ifdef CPU_SEQ_WATCHDOG_EN
    logic              timeout_q, timeout_d;
`endif

    logic w_is_stop;
    logic unused_instr_bits;

    assign w_is_stop         = (instr[6:0] == STOP_OPC);
    assign unused_instr_bits = ^instr[27:7];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        cycles_d    = cycles_q;
        test_id_d   = test_id_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        done_d      = done_q;
        pass_d      = pass_q;
`ifdef CPU_SEQ_WATCHDOG_EN
        timeout_d   = timeout_q;
`endif
        ld_ready    = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        exp_idx     = '0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD_D;
                    idx_d       = '0;
                    chk_d       = '0;
                    cycles_d    = '0;
                    test_id_d   = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
`ifdef CPU_SEQ_WATCHDOG_EN
                    timeout_d   = 1'b0;
`endif
                end
            end
            S_LOAD_D: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    wen_ext_2   = 1'b1;
                    wdata_ext_2 = ld_data;
                    addr_ext_2  = ADDR_W'(idx_q) << 3;
                    if (idx_q == IDX_W'(DMEM_DEPTH - 1)) begin
                        idx_d   = '0;
                        state_d = S_LOAD_I;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LOAD_I: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    wen_ext   = 1'b1;
                    wdata_ext = ld_data;
                    addr_ext  = ADDR_W'(idx_q) << 2;
                    if (idx_q == IDX_W'(IMEM_DEPTH - 1)) begin
                        idx_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                cpu_enable = 1'b1;
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (w_is_stop) begin
                    test_id_d = instr[31:28];
                    chk_d     = '0;
                    if (CHK_LEN == 0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
`ifdef CPU_SEQ_WATCHDOG_EN
                else if (cycles_d == CYC_W'(TIMEOUT_CYC)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_CHECK: begin
                // Reads are issued for offsets 0..CHK_LEN-1; each compare lags its read by one cycle.
                if (chk_q < 16'(CHK_LEN)) begin
                    ren_ext_2  = 1'b1;
                    addr_ext_2 = (ADDR_W'(CHK_BASE) + ADDR_W'(chk_q)) << 3;
                end
                if (chk_q != 16'd0) begin
                    exp_idx = chk_q - 16'd1;
                    if (rdata_ext_2 != exp_data) begin
                        if (err_cnt_q == 16'd0) begin
                            first_err_d = chk_q - 16'd1;
                        end
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                    end
                end
                if (chk_q == 16'(CHK_LEN)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 16'd0);
                end else begin
                    chk_d = chk_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            chk_q       <= '0;
            cycles_q    <= '0;
            test_id_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
`ifdef CPU_SEQ_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            cycles_q    <= cycles_d;
            test_id_q   <= test_id_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
`ifdef CPU_SEQ_WATCHDOG_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign done          = done_q;
    assign pass          = pass_q;
    assign test_id       = test_id_q;
    assign cycles        = cycles_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
`ifdef CPU_SEQ_WATCHDOG_EN
    assign timeout       = timeout_q;
`else
    assign timeout       = 1'b0;
`endif

endmodule
`default_nettype wire
